// File: rtl/uart_pkg.sv
// Shared definitions for the UART sample byte interface: FSM states,
// default header value and byte-count helper.
package uart_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam logic [7:0]  DEF_HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        GUARD = 3'd3,
        WAIT  = 3'd4
    } ser_state_t;

    // Number of whole bytes needed to carry a w-bit sample.
    function automatic int unsigned nbytes(input int unsigned w);
        return (w + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout always presents the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/uart_sample_serializer.sv
// Queues FIR samples and sends each as an optional header byte followed by
// the padded sample bytes over the UART start/busy/data handshake.
module uart_sample_serializer
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned SIGN_EXT  = 1,
    parameter int unsigned HDR_EN    = 1,
    parameter logic [7:0]  HDR_BYTE  = DEF_HDR_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SAMPLE_W-1:0]    s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   idle
);

    localparam int unsigned NBYTES = nbytes(SAMPLE_W);
    localparam int unsigned PADW   = NBYTES * BYTE_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    ser_state_t          r_state;
    logic [PADW-1:0]     r_shift;
    logic [IDX_W-1:0]    r_idx;
    logic                r_hdr_pending;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;

    logic [SAMPLE_W-1:0] w_dout;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [PADW-1:0]     w_pad;
    logic [IDX_W-1:0]    w_byte_sel;
    logic [7:0]          w_cur_byte;

    assign w_pop = (r_state == LOAD);

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .pop   (w_pop),
        .din   (s_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_cnt)
    );

    // Widen the head sample to whole bytes, filling the top byte per SIGN_EXT.
    assign w_pad = (SIGN_EXT != 0) ? PADW'($signed(w_dout)) : PADW'(w_dout);

    assign w_byte_sel = (MSB_FIRST != 0) ? (IDX_W'(NBYTES - 1) - r_idx) : r_idx;

    always_comb begin
        w_cur_byte = 8'h00;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (w_byte_sel == IDX_W'(b)) begin
                w_cur_byte = r_shift[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // Frame sequencer; GUARD masks the transmitter's one-cycle busy latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_idx         <= '0;
            r_hdr_pending <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_shift       <= w_pad;
                    r_idx         <= '0;
                    r_hdr_pending <= (HDR_EN != 0);
                    r_state       <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_hdr_pending ? HDR_BYTE : w_cur_byte;
                        r_state    <= GUARD;
                    end
                end
                GUARD: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if (r_hdr_pending) begin
                            r_hdr_pending <= 1'b0;
                            r_state       <= SEND;
                        end else if (r_idx < IDX_W'(NBYTES - 1)) begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= SEND;
                        end else if (!w_empty) begin
                            r_state <= LOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign s_ready  = !w_full;
    assign idle     = (r_state == IDLE) && w_empty;

endmodule

// File: tb/tb_uart_sample_serializer.sv
// Self-checking bench: constant vector tables, hand sequences for timing
// corners, and a random stream scored against a byte-level reference model.
module tb_uart_sample_serializer;

    localparam int unsigned DEPTH = 4;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    typedef struct {
        logic [11:0] sample;
        logic [7:0]  se0;
        logic [7:0]  se1;
        logic [7:0]  ze0;
        logic [7:0]  ze1;
    } v12_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main instance: 16-bit, header, LSB first, sign-extend
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  fifo_cnt;
    logic        idle;
    logic        force_busy = 1'b0;
    int          busy_len = 20;
    int          busy_cnt;
    int          viol = 0;
    bq_t         got_q;
    bq_t         exp_q;

    // 12-bit, MSB first, no header; a = sign-extend, b = zero-pad
    logic [11:0] s12_data = '0;
    logic        s12_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [7:0]  a_tx_data, b_tx_data;
    logic        a_start, b_start;
    logic        a_busy, b_busy;
    logic [2:0]  a_cnt, b_cnt;
    logic        a_idle, b_idle;
    int          a_bc, b_bc;
    bq_t         a_got, b_got;

    int total = 0;
    int bad = 0;

    assign tx_busy = (busy_cnt != 0) || force_busy;
    assign a_busy  = (a_bc != 0);
    assign b_busy  = (b_bc != 0);

    uart_sample_serializer #(
        .SAMPLE_W(16), .DEPTH(DEPTH), .MSB_FIRST(0), .SIGN_EXT(1), .HDR_EN(1), .HDR_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .fifo_cnt(fifo_cnt), .idle(idle)
    );

    uart_sample_serializer #(
        .SAMPLE_W(12), .DEPTH(DEPTH), .MSB_FIRST(1), .SIGN_EXT(1), .HDR_EN(0), .HDR_BYTE(8'hA5)
    ) dut_se (
        .clk(clk), .rst(rst), .s_data(s12_data), .s_valid(s12_valid), .s_ready(a_ready),
        .tx_data(a_tx_data), .tx_start(a_start), .tx_busy(a_busy),
        .fifo_cnt(a_cnt), .idle(a_idle)
    );

    uart_sample_serializer #(
        .SAMPLE_W(12), .DEPTH(DEPTH), .MSB_FIRST(1), .SIGN_EXT(0), .HDR_EN(0), .HDR_BYTE(8'hA5)
    ) dut_ze (
        .clk(clk), .rst(rst), .s_data(s12_data), .s_valid(s12_valid), .s_ready(b_ready),
        .tx_data(b_tx_data), .tx_start(b_start), .tx_busy(b_busy),
        .fifo_cnt(b_cnt), .idle(b_idle)
    );

    // Byte k (k=0 least significant) of a w-bit sample after padding.
    function automatic logic [7:0] ref_byte(input logic [31:0] raw, input int w,
                                            input bit se, input int k);
        longint v;
        v = longint'(raw);
        if (se && raw[w-1]) v = v - (longint'(1) << w);
        return 8'((v >>> (8 * k)) & 255);
    endfunction

    // Behavioural transmitters: busy rises the cycle after a start is seen.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= 0;
        end else if (tx_start) begin
            if (tx_busy) viol <= viol + 1;
            got_q.push_back(tx_data);
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_bc <= 0;
            b_bc <= 0;
        end else begin
            if (a_start) begin
                if (a_busy) viol <= viol + 1;
                a_got.push_back(a_tx_data);
                a_bc <= 5;
            end else if (a_bc > 0) a_bc <= a_bc - 1;
            if (b_start) begin
                if (b_busy) viol <= viol + 1;
                b_got.push_back(b_tx_data);
                b_bc <= 5;
            end else if (b_bc > 0) b_bc <= b_bc - 1;
        end
    end

    // Reference model: every accepted sample expands to header + LSB-first bytes.
    always @(posedge clk) begin
        if (rst && s_valid && s_ready) begin
            exp_q.push_back(8'hA5);
            for (int k = 0; k < 2; k++) exp_q.push_back(ref_byte(32'(s_data), 16, 1'b1, k));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cmp_q(input string name, input bq_t g, input bq_t e);
        check({name, "_len"}, longint'(g.size()), longint'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++)
            check($sformatf("%s[%0d]", name, i), g[i], e[i]);
    endtask

    task automatic push_sample(input logic [15:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 3000) begin tick(); n++; end
        if (n >= 3000) check("push_timeout", 0, 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(idle && a_idle && b_idle) && n < budget) begin tick(); n++; end
        check({name, "_idle"}, longint'(idle && a_idle && b_idle), 1);
    endtask

    initial begin
        vec_t tbl [4];
        v12_t t12 [4];
        bq_t  e;
        int   n;
        int   acc;
        int   seen;

        tbl[0] = '{16'h1234, 8'hA5, 8'h34, 8'h12};
        tbl[1] = '{16'h8001, 8'hA5, 8'h01, 8'h80};
        tbl[2] = '{16'hFFFF, 8'hA5, 8'hFF, 8'hFF};
        tbl[3] = '{16'h00C3, 8'hA5, 8'hC3, 8'h00};
        t12[0] = '{12'h9AB, 8'hF9, 8'hAB, 8'h09, 8'hAB};
        t12[1] = '{12'h123, 8'h01, 8'h23, 8'h01, 8'h23};
        t12[2] = '{12'h800, 8'hF8, 8'h00, 8'h08, 8'h00};
        t12[3] = '{12'h7FF, 8'h07, 8'hFF, 8'h07, 8'hFF};

        // reset state
        tick(); tick();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_idle", idle, 1);
        rst = 1'b1;
        tick();

        // first-byte latency: tx_start three edges after the write edge
        busy_len = 20;
        got_q.delete();
        s_data = 16'h1234; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("lat_cnt_after_write", fifo_cnt, 1);
        check("lat_idle_after_write", idle, 0);
        tick();
        check("lat_start_e1", tx_start, 0);
        tick();
        check("lat_start_e2", tx_start, 0);
        check("lat_cnt_after_pop", fifo_cnt, 0);
        tick();
        check("lat_start_e3", tx_start, 1);
        check("lat_hdr", tx_data, 8'hA5);
        wait_idle("lat", 500);
        e.delete(); e.push_back(8'hA5); e.push_back(8'h34); e.push_back(8'h12);
        cmp_q("lat_bytes", got_q, e);

        // table: main instance
        for (int i = 0; i < 4; i++) begin
            got_q.delete();
            busy_len = int'($urandom_range(1, 30));
            push_sample(tbl[i].sample);
            wait_idle($sformatf("tbl%0d", i), 1000);
            e.delete(); e.push_back(tbl[i].b0); e.push_back(tbl[i].b1); e.push_back(tbl[i].b2);
            cmp_q($sformatf("tbl%0d_bytes", i), got_q, e);
        end

        // table: 12-bit MSB first, sign-extend vs zero-pad
        for (int i = 0; i < 4; i++) begin
            a_got.delete(); b_got.delete();
            s12_data = t12[i].sample; s12_valid = 1'b1;
            tick();
            s12_valid = 1'b0;
            wait_idle($sformatf("t12_%0d", i), 500);
            e.delete(); e.push_back(t12[i].se0); e.push_back(t12[i].se1);
            cmp_q($sformatf("t12_%0d_se", i), a_got, e);
            e.delete(); e.push_back(t12[i].ze0); e.push_back(t12[i].ze1);
            cmp_q($sformatf("t12_%0d_ze", i), b_got, e);
        end

        // burst of six with slow transmitter: 4 queued + 1 in flight
        busy_len = 50;
        got_q.delete(); exp_q.delete();
        acc = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 16'($urandom);
            if (!s_ready) break;
            tick();
            acc++;
        end
        check("burst_accepts", acc, 5);
        check("burst_full_cnt", fifo_cnt, DEPTH);
        n = 0;
        while (!s_ready && n < 3000) begin tick(); n++; end
        check("burst_6th_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        wait_idle("burst", 6000);
        cmp_q("burst_bytes", got_q, exp_q);

        // push during LOAD with DEPTH-1 queued, then stream to wrap pointers
        busy_len = 50;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) push_sample(16'($urandom));
        check("wrap_cnt_queued", fifo_cnt, DEPTH - 1);
        n = 0;
        while (got_q.size() < 3 && n < 1000) begin tick(); n++; end
        check("wrap_first_frame", longint'(got_q.size()), 3);
        n = 0;
        while (tx_busy && n < 200) begin tick(); n++; end
        tick();
        check("wrap_cnt_in_load", fifo_cnt, DEPTH - 1);
        s_data = 16'($urandom); s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("wrap_cnt_after_pushpop", fifo_cnt, DEPTH - 1);
        check("wrap_ready_after_pushpop", s_ready, 1);
        busy_len = int'($urandom_range(1, 8));
        for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            push_sample(16'($urandom));
        end
        wait_idle("wrap", 8000);
        cmp_q("wrap_bytes", got_q, exp_q);

        // transmitter busy for 100 cycles before the first SEND
        busy_len = 10;
        got_q.delete();
        force_busy = 1'b1;
        push_sample(16'hBEEF);
        seen = 0;
        repeat (100) begin tick(); if (tx_start) seen++; end
        check("hold_no_start", seen, 0);
        force_busy = 1'b0;
        tick();
        check("hold_start_after_release", tx_start, 1);
        check("hold_hdr", tx_data, 8'hA5);
        tick();
        check("hold_single_pulse", tx_start, 0);
        wait_idle("hold", 500);
        e.delete(); e.push_back(8'hA5); e.push_back(8'hEF); e.push_back(8'hBE);
        cmp_q("hold_bytes", got_q, e);

        // reset in the middle of a frame, then a fresh frame
        busy_len = 20;
        got_q.delete();
        push_sample(16'h5A5A);
        push_sample(16'h1111);
        n = 0;
        while (!(tx_start && got_q.size() == 1) && n < 500) begin tick(); n++; end
        check("mid_second_start", tx_start, 1);
        rst = 1'b0;
        #1;
        check("mid_start_async_drop", tx_start, 0);
        tick();
        check("mid_cnt_in_rst", fifo_cnt, 0);
        rst = 1'b1;
        tick();
        check("mid_cnt_after", fifo_cnt, 0);
        check("mid_idle_after", idle, 1);
        check("mid_ready_after", s_ready, 1);
        got_q.delete();
        push_sample(16'h0F0F);
        wait_idle("fresh", 500);
        e.delete(); e.push_back(8'hA5); e.push_back(8'h0F); e.push_back(8'h0F);
        cmp_q("fresh_bytes", got_q, e);

        check("start_while_busy", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
